// File: rtl/full_adder.sv
// full_adder: one-bit full adder, purely combinational.
// It is built from two half adders. The first adds the operand bits.
// The second adds the carry-in to that partial sum.
// The two partial carries can never both be 1, so OR-ing them gives the carry-out.
module full_adder (
    input  logic [1:0] in,
    input  logic       c_in,
    output logic       sum,
    output logic       c_out
);

    logic w_s0;
    logic w_c0;
    logic w_c1;

    // Operand bits
    half_adder u_ha0 (
        .in    (in),
        .sum   (w_s0),
        .carry (w_c0)
    );

    // Partial sum plus incoming carry
    half_adder u_ha1 (
        .in    ({c_in, w_s0}),
        .sum   (sum),
        .carry (w_c1)
    );

    // Merge the two partial carries
    always_comb begin
        c_out = w_c0 | w_c1;
    end

endmodule

// File: rtl/half_adder.sv
// half_adder: one-bit half adder, purely combinational.
// sum is the XOR of the two input bits, carry is their AND.
module half_adder (
    input  logic [1:0] in,
    output logic       sum,
    output logic       carry
);

    // Sum and carry of two bits
    always_comb begin
        sum   = in[0] ^ in[1];
        carry = in[0] & in[1];
    end

endmodule

// File: rtl/adder_16.sv
// adder_16: WIDTH-bit ripple-carry adder with one registered output stage.
// The datapath is a chain of full_adder cells and uses no '+' operator.
// The carry into the top bit and the carry out of it are both visible here.
// That lets the signed-overflow flag be computed as their XOR.
// When in_valid is low, the result registers are not enabled.
// So whatever is on the operand pins that cycle never reaches the outputs.
module adder_16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             c_in,
    output logic [WIDTH-1:0] out,
    output logic             c_out,
    output logic             ovf,
    output logic             out_valid
);

    // w_carry[i] is the carry into bit i; w_carry[WIDTH] is the final carry-out
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    logic [WIDTH-1:0] r_out;
    logic             r_c_out;
    logic             r_ovf;
    logic             r_vld;

    assign w_carry[0] = c_in;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_fa
            full_adder u_fa (
                .in    ({in1[gi], in0[gi]}),
                .c_in  (w_carry[gi]),
                .sum   (w_sum[gi]),
                .c_out (w_carry[gi+1])
            );
        end
    endgenerate

    // Signed overflow: the carry into the MSB disagrees with the carry out of it
    always_comb begin
        w_ovf = w_carry[WIDTH-1] ^ w_carry[WIDTH];
    end

    // Result register.
    // Reset wins over in_valid.
    // The result loads only on a valid cycle and holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
            r_vld   <= 1'b0;
        end else begin
            r_vld <= in_valid;
            if (in_valid) begin
                r_out   <= w_sum;
                r_c_out <= w_carry[WIDTH];
                r_ovf   <= w_ovf;
            end
        end
    end

    assign out       = r_out;
    assign c_out     = r_c_out;
    assign ovf       = r_ovf;
    assign out_valid = r_vld;

endmodule

// File: tb/tb_adder_16.sv
// tb_adder_16: self-checking bench for adder_16 and its cells.
// The half and full adder cells are checked exhaustively against truth tables.
// The 16-bit adder is driven through a scoreboard of expected results.
// Those results come from directed vector tables and from an arithmetic reference model.
module tb_adder_16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in0;
    logic [15:0] in1;
    logic        c_in;
    logic [15:0] out;
    logic        c_out;
    logic        ovf;
    logic        out_valid;

    logic [1:0]  ha_in;
    logic        ha_s;
    logic        ha_c;
    logic [1:0]  fa_in;
    logic        fa_cin;
    logic        fa_s;
    logic        fa_c;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } res_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        res_t        exp;
    } vec_t;

    res_t q[$];
    res_t last;

    always #5 clk = ~clk;

    adder_16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in0       (in0),
        .in1       (in1),
        .c_in      (c_in),
        .out       (out),
        .c_out     (c_out),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    half_adder u_ha (.in(ha_in), .sum(ha_s), .carry(ha_c));
    full_adder u_fa (.in(fa_in), .c_in(fa_cin), .sum(fa_s), .c_out(fa_c));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: 17-bit arithmetic sum; overflow when the operand signs agree and the result sign differs
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic ci);
        res_t        r;
        logic [16:0] t;
        t   = {1'b0, a} + {1'b0, b} + {16'd0, ci};
        r.s = t[15:0];
        r.c = t[16];
        r.o = (a[15] == b[15]) && (t[15] != a[15]);
        return r;
    endfunction

    // One clock: drive, push the expected result if valid, then check after the edge
    task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic r, input res_t exp, input string tag);
        res_t e;
        rst = r; in_valid = v; in0 = a; in1 = b; c_in = ci;
        if (v && !r) q.push_back(exp);
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v && !r});
        if (r) begin
            chk({tag, ".rst_out"}, {16'd0, out}, 32'd0);
            chk({tag, ".rst_flags"}, {30'd0, c_out, ovf}, 32'd0);
            q.delete();
            last = '0;
        end else if (out_valid) begin
            if (q.size() == 0) begin
                chk({tag, ".unexpected_result"}, 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk({tag, ".out"}, {16'd0, out}, {16'd0, e.s});
                chk({tag, ".c_out"}, {31'd0, c_out}, {31'd0, e.c});
                chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, e.o});
                last = e;
            end
        end else begin
            chk({tag, ".hold"}, {15'd0, out, c_out, ovf}, {15'd0, last});
        end
    endtask

    initial begin
        vec_t        vecs[9];
        logic [3:0]  ha_es;
        logic [3:0]  ha_ec;
        logic [7:0]  fa_es;
        logic [7:0]  fa_ec;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;

        rst = 1'b1; in_valid = 1'b0; in0 = '0; in1 = '0; c_in = 1'b0;
        last = '0;

        // Cell truth tables, indexed by {c_in, in[1], in[0]}
        ha_es = 4'b0110; ha_ec = 4'b1000;
        fa_es = 8'b1001_0110; fa_ec = 8'b1110_1000;
        for (int i = 0; i < 4; i++) begin
            ha_in = i[1:0];
            #1;
            chk($sformatf("ha[%0d].sum", i), {31'd0, ha_s}, {31'd0, ha_es[i]});
            chk($sformatf("ha[%0d].carry", i), {31'd0, ha_c}, {31'd0, ha_ec[i]});
        end
        for (int i = 0; i < 8; i++) begin
            fa_in = i[1:0]; fa_cin = i[2];
            #1;
            chk($sformatf("fa[%0d].sum", i), {31'd0, fa_s}, {31'd0, fa_es[i]});
            chk($sformatf("fa[%0d].c_out", i), {31'd0, fa_c}, {31'd0, fa_ec[i]});
        end

        // Directed vectors: {a, b, c_in, {sum, c_out, ovf}}
        vecs[0] = '{16'h0000, 16'h0000, 1'b0, '{16'h0000, 1'b0, 1'b0}};
        vecs[1] = '{16'h0001, 16'h0001, 1'b0, '{16'h0002, 1'b0, 1'b0}};
        vecs[2] = '{16'h8000, 16'h8000, 1'b0, '{16'h0000, 1'b1, 1'b1}};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1}};
        vecs[4] = '{16'hFFFF, 16'h0000, 1'b1, '{16'h0000, 1'b1, 1'b0}};
        vecs[5] = '{16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0}};
        vecs[6] = '{16'h1234, 16'h4321, 1'b1, '{16'h5556, 1'b0, 1'b0}};
        vecs[7] = '{16'h8000, 16'hFFFF, 1'b0, '{16'h7FFF, 1'b1, 1'b1}};
        vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, '{16'hFFFF, 1'b1, 1'b0}};

        // Reset state: two cycles held in reset
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, '0, "reset0");
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, '0, "reset1");
        // Idle after release: nothing valid, outputs still zero
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, '0, "idle");

        // Table vectors back-to-back
        foreach (vecs[i])
            cycle(1'b1, vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0, vecs[i].exp,
                  $sformatf("vec%0d", i));

        // Hold: drop in_valid and wiggle operands; previous result must stay put
        cycle(1'b0, 16'hAAAA, 16'h5555, 1'b1, 1'b0, '0, "hold0");
        cycle(1'b0, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, '0, "hold1");

        // Load a nonzero result, then reset together with a valid op (op discarded)
        cycle(1'b1, 16'h0F0F, 16'h0101, 1'b0, 1'b0, '{16'h1010, 1'b0, 1'b0}, "pre_rst");
        cycle(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, '0, "rst_mid");
        // First valid after reset appears one edge later
        cycle(1'b1, 16'h0003, 16'h0004, 1'b0, 1'b0, '{16'h0007, 1'b0, 1'b0}, "post_rst");

        // Streaming: random back-to-back operand sets against the model
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            cycle(1'b1, ra, rb, rc, 1'b0, model(ra, rb, rc), $sformatf("rnd%0d", i));
        end
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, '0, "drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
